// File: rtl/seq_detect_prog_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_prog_pkg
//  Brief    : Shared FSM state encoding and length constants for the
//             programmable serial sequence detector.
//  Revision : 1.0  initial release
// ============================================================================
package seq_detect_prog_pkg;

  // Detector configuration state: no valid pattern loaded, or actively matching
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Shortest pattern the detector accepts
  localparam int C_MIN_LEN = 2;

  // A length is legal when it lies within [C_MIN_LEN, max_len]
  function automatic logic len_legal(input int len, input int max_len);
    return (len >= C_MIN_LEN) && (len <= max_len);
  endfunction

endpackage : seq_detect_prog_pkg
`default_nettype wire

// File: rtl/seq_detect_prog_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Brief    : W-bit up-counter with synchronous clear that holds at all-ones.
//             Clear has priority over increment.
//  Revision : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Next count: clear wins, otherwise step unless already saturated
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  // Count register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/seq_detect_prog.sv
`default_nettype none
// ============================================================================
//  Module   : seq_detect_prog
//  Brief    : Runtime-programmable serial pattern detector. Supports pattern
//             lengths 2..MAX_LEN, overlapping / non-overlapping detection and
//             Mealy (same-cycle) or Moore (one-cycle-late) match reporting,
//             with a saturating detection counter.
//  Revision : 1.0  initial release
// ============================================================================
module seq_detect_prog
  import seq_detect_prog_pkg::*;
#(
  parameter int  MAX_LEN = 8,
  parameter int  CNT_W   = 8,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               din,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cfg_moore,
  output logic               match,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  // Fill counter saturates once the whole history window holds valid bits
  localparam logic [LEN_W-1:0] C_FILL_MAX = LEN_W'(MAX_LEN);

  // Control state and latched configuration
  state_e             state_q, state_d;
  logic [MAX_LEN-1:0] pat_q,   pat_d;
  logic [LEN_W-1:0]   len_q,   len_d;
  logic               ovl_q,   ovl_d;
  logic               moore_q, moore_d;
  logic               err_q,   err_d;

  // Datapath: received-bit history, valid-bit count, registered hit
  logic [MAX_LEN-1:0] hist_q,  hist_d;
  logic [LEN_W-1:0]   fill_q,  fill_d;
  logic               mhit_q,  mhit_d;

  // Combinational match evaluation
  logic [MAX_LEN-1:0] w_cand;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_len_ok;
  logic               w_filled;
  logic               w_hit;

  // The oldest history bit is only ever shifted out, never compared:
  // a len-bit pattern needs len-1 stored bits plus the live din.
  logic               w_unused_hist_msb;
  assign w_unused_hist_msb = hist_q[MAX_LEN-1];

  assign w_len_ok = len_legal(int'(cfg_len), MAX_LEN);

  // In RUN, len_q >= 2, so len_q-1 never underflows
  assign w_filled = (fill_q >= (len_q - LEN_W'(1)));

  // Hit detection: newest len bits (history + live din) against the pattern
  always_comb begin
    w_cand = {hist_q[MAX_LEN-2:0], din};
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(len_q));
    end
    w_hit = (state_q == ST_RUN) && en && !cfg_load && w_filled &&
            (((w_cand ^ pat_q) & w_mask) == '0);
  end

  // Mealy reports the live hit, Moore the registered one; IDLE forces 0
  assign match = (state_q == ST_RUN) && (moore_q ? mhit_q : w_hit);

  // Next-state: configuration capture has priority over bit consumption
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    moore_d = moore_q;
    err_d   = err_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    mhit_d  = w_hit;

    if (cfg_load) begin
      hist_d = '0;
      fill_d = '0;
      if (w_len_ok) begin
        state_d = ST_RUN;
        pat_d   = cfg_pattern;
        len_d   = cfg_len;
        ovl_d   = cfg_overlap;
        moore_d = cfg_moore;
        err_d   = 1'b0;
      end else begin
        // Illegal length: drop any previous configuration entirely
        state_d = ST_IDLE;
        pat_d   = '0;
        len_d   = '0;
        ovl_d   = 1'b0;
        moore_d = 1'b0;
        err_d   = 1'b1;
      end
    end else if ((state_q == ST_RUN) && en) begin
      hist_d = w_cand;
      if (w_hit && !ovl_q) begin
        // Non-overlapping: bits of this detection may not seed the next one
        fill_d = '0;
      end else if (fill_q != C_FILL_MAX) begin
        fill_d = fill_q + LEN_W'(1);
      end
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      moore_q <= 1'b0;
      err_q   <= 1'b0;
      hist_q  <= '0;
      fill_q  <= '0;
      mhit_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      moore_q <= moore_d;
      err_q   <= err_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      mhit_q  <= mhit_d;
    end
  end

  assign cfg_err = err_q;

  // Detection counter, cleared by every configuration load
  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cfg_load),
    .inc (w_hit),
    .q   (match_cnt)
  );

endmodule : seq_detect_prog
`default_nettype wire

// File: tb/tb_seq_detect_prog.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_detect_prog
//  Brief    : Directed self-checking bench for seq_detect_prog. Expected match
//             values are queued as bits are driven and compared as the DUT
//             presents them; a second instance uses a 2-bit counter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seq_detect_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int CNT_W   = 8;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               en = 1'b0;
  logic               din = 1'b0;
  logic               cfg_load = 1'b0;
  logic [MAX_LEN-1:0] cfg_pattern = '0;
  logic [LEN_W-1:0]   cfg_len = '0;
  logic               cfg_overlap = 1'b0;
  logic               cfg_moore = 1'b0;
  logic               match;
  logic [CNT_W-1:0]   match_cnt;
  logic               cfg_err;
  logic               match2;
  logic [1:0]         cnt2;
  logic               err2;

  int   n_vec = 0;
  int   n_err = 0;
  logic sb_q[$];

  seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .din(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_moore(cfg_moore), .match(match), .match_cnt(match_cnt), .cfg_err(cfg_err)
  );

  seq_detect_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .din(din), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .cfg_moore(cfg_moore), .match(match2), .match_cnt(cnt2), .cfg_err(err2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bit period: drive after the edge, compare the oldest queued expectation mid-cycle
  task automatic step(input logic e, input logic d, input logic hit_exp, input string tag);
    logic exp_m;
    en  = e;
    din = d;
    sb_q.push_back(hit_exp);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL %s: scoreboard empty, observed %0d", tag, match);
    end else begin
      exp_m = sb_q.pop_front();
      check({tag, "_match"}, 32'(match), 32'(exp_m));
      check({tag, "_match2"}, 32'(match2), 32'(exp_m));
    end
    @(posedge clk);
    #1;
  endtask

  // Apply a load strobe, then scramble the cfg inputs to prove they were latched
  task automatic load(input logic [MAX_LEN-1:0] p, input int len, input logic ovl,
                      input logic moo, input logic e, input logic d);
    cfg_load    = 1'b1;
    cfg_pattern = p;
    cfg_len     = LEN_W'(len);
    cfg_overlap = ovl;
    cfg_moore   = moo;
    en          = e;
    din         = d;
    @(posedge clk);
    #1;
    cfg_load    = 1'b0;
    en          = 1'b0;
    din         = 1'b0;
    cfg_pattern = ~p;
    cfg_len     = '0;
    cfg_overlap = ~ovl;
    cfg_moore   = ~moo;
    sb_q.delete();
    // Moore output lags by one cycle: the first observed slot is always quiet
    if (moo) sb_q.push_back(1'b0);
  endtask

  // Stream n bits MSB first with per-bit expected hits, optionally with en=0 gaps
  task automatic run_stream(input logic [31:0] bits, input logic [31:0] hits, input int n,
                            input string tag, input logic gaps);
    for (int i = 0; i < n; i++) begin
      step(1'b1, bits[n-1-i], hits[n-1-i], tag);
      if (gaps) step(1'b0, 1'($urandom_range(0, 1)), 1'b0, {tag, "_gap"});
    end
  endtask

  initial begin
    // Reset asserted with en/din active
    rst = 1'b0; en = 1'b1; din = 1'b1;
    #12;
    check("rst_match", 32'(match), 0);
    check("rst_cnt", 32'(match_cnt), 0);
    check("rst_err", 32'(cfg_err), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // No configuration yet: input is ignored
    run_stream(32'b11011, 32'b00000, 5, "idle_nocfg", 1'b0);
    check("idle_cnt", 32'(match_cnt), 0);

    // Overlapping Mealy 11011
    load(8'b00011011, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ovl_err", 32'(cfg_err), 0);
    run_stream(32'b11011011, 32'b00001001, 8, "ovl", 1'b0);
    check("ovl_cnt", 32'(match_cnt), 2);

    // Non-overlapping, same stream
    load(8'b00011011, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    run_stream(32'b11011011, 32'b00001000, 8, "novl", 1'b0);
    check("novl_cnt", 32'(match_cnt), 1);

    // en gaps between every bit
    load(8'b00011011, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    run_stream(32'b11011011, 32'b00001001, 8, "gaps", 1'b1);
    check("gaps_cnt", 32'(match_cnt), 2);

    // Moore 101 overlapping: match one cycle after bits 2 and 4
    load(8'b00000101, 3, 1'b1, 1'b1, 1'b0, 1'b0);
    run_stream(32'b10101, 32'b00101, 5, "moore", 1'b0);
    step(1'b0, 1'b0, 1'b0, "moore_flush");
    check("moore_cnt", 32'(match_cnt), 2);

    // Illegal lengths
    load(8'b00000011, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("len0_err", 32'(cfg_err), 1);
    run_stream(32'b111, 32'b000, 3, "len0", 1'b0);
    load(8'b00000011, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("len1_err", 32'(cfg_err), 1);
    load(8'b00000011, MAX_LEN + 1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("len9_err", 32'(cfg_err), 1);
    check("len9_err2", 32'(err2), 1);
    run_stream(32'b111, 32'b000, 3, "len9", 1'b0);
    check("len9_cnt", 32'(match_cnt), 0);

    // Reset clears the sticky error
    rst = 1'b0;
    #2;
    check("rst_err_clr", 32'(cfg_err), 0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Valid load recovers; bit presented with the load strobe is discarded
    load(8'b00000011, 2, 1'b1, 1'b0, 1'b1, 1'b1);
    check("len2_err", 32'(cfg_err), 0);
    run_stream(32'b111, 32'b011, 3, "len2", 1'b0);
    check("len2_cnt", 32'(match_cnt), 2);

    // Maximum length, non-overlapping, pattern sent twice back to back
    load(8'b10110011, MAX_LEN, 1'b0, 1'b0, 1'b0, 1'b0);
    check("lenmax_err", 32'(cfg_err), 0);
    run_stream(32'b1011001110110011, 32'b0000000100000001, 16, "lenmax", 1'b0);
    check("lenmax_cnt", 32'(match_cnt), 2);

    // Reset in the middle of a partial match
    load(8'b00011011, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    run_stream(32'b1101101, 32'b0000100, 7, "prerst", 1'b0);
    check("prerst_cnt", 32'(match_cnt), 1);
    en = 1'b1; din = 1'b1;
    rst = 1'b0;
    #2;
    check("midrst_match", 32'(match), 0);
    check("midrst_cnt", 32'(match_cnt), 0);
    check("midrst_err", 32'(cfg_err), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    sb_q.delete();
    step(1'b1, 1'b1, 1'b0, "postrst");
    load(8'b00011011, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    run_stream(32'b11011, 32'b00001, 5, "reload", 1'b0);
    check("reload_cnt", 32'(match_cnt), 1);

    // Saturation: five overlapping hits on a 2-bit counter
    load(8'b00000011, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    run_stream(32'b111111, 32'b011111, 6, "sat", 1'b0);
    check("sat_cnt2", 32'(cnt2), 3);
    check("sat_cnt8", 32'(match_cnt), 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_seq_detect_prog
`default_nettype wire

// File: doc/seq_detect_prog.md
SEQ_DETECT_PROG -- requirements
Module: seq_detect_prog

Interface
REQ-001 SHALL have parameter MAX_LEN, default 8, maximum pattern length in bits (2..32).
REQ-002 SHALL have parameter CNT_W, default 8, width of match counter.
REQ-003 SHALL have localparam LEN_W = $clog2(MAX_LEN+1), width of length fields.
REQ-004 SHALL have port clk  input  1  clock, rising-edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  din qualifier; one serial bit consumed per cycle with en=1.
REQ-007 SHALL have port din  input  1  serial data bit.
REQ-008 SHALL have port cfg_load  input  1  one-cycle strobe; captures cfg_* fields.
REQ-009 SHALL have port cfg_pattern  input  MAX_LEN  pattern; bit [len-1] = first bit received, bit [0] = last.
REQ-010 SHALL have port cfg_len  input  LEN_W  pattern length in bits.
REQ-011 SHALL have port cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-012 SHALL have port cfg_moore  input  1  1 = registered (Moore) match, 0 = combinational (Mealy) match.
REQ-013 SHALL have port match  output  1  pattern-detected pulse.
REQ-014 SHALL have port match_cnt  output  CNT_W  saturating count of detections.
REQ-015 SHALL have port cfg_err  output  1  sticky flag: last cfg_load carried an illegal length.

Function
REQ-016 SHALL implement a two-state FSM: IDLE (no valid configuration) and RUN.
REQ-017 IDLE -> RUN on cfg_load with 2 <= cfg_len <= MAX_LEN; cfg_pattern, cfg_len, cfg_overlap, cfg_moore latched and cfg_err cleared.
REQ-018 cfg_load with cfg_len < 2 or > MAX_LEN SHALL force IDLE and set cfg_err; prior configuration discarded.
REQ-019 In IDLE, din/en SHALL be ignored and match SHALL be 0.
REQ-020 SHALL keep a MAX_LEN-bit history shift register and a fill counter (0..MAX_LEN, saturating) of valid bits since last clear.
REQ-021 Each RUN cycle with en=1: history shifts left, din enters bit 0, fill increments.
REQ-022 Hit condition SHALL be: en=1, fill >= len-1, and {history[len-2:0], din} equals pattern[len-1:0].
REQ-023 Mealy mode: match = hit in the same cycle (combinational from din/en).
REQ-024 Moore mode: match SHALL equal hit registered, asserted exactly one cycle after the detecting bit, for one cycle.
REQ-025 Overlapping mode: history and fill continue unchanged after a hit.
REQ-026 Non-overlapping mode: on a hit, fill SHALL clear to 0 so no bit of a detected pattern contributes to the next detection.
REQ-027 en=0 SHALL hold history, fill and counter; no hit.
REQ-028 Every hit SHALL increment match_cnt by 1, saturating at 2^CNT_W-1.
REQ-029 cfg_load SHALL clear history, fill, match_cnt and the Moore match register; cfg_load wins over a simultaneous en=1 (that bit discarded, no hit).
REQ-030 Mode/pattern changes SHALL only take effect via cfg_load.

Reset
REQ-031 rst=0 SHALL asynchronously force state IDLE, history 0, fill 0, match_cnt 0, Moore match register 0, cfg_err 0, latched config 0.
REQ-032 match SHALL read 0 during reset regardless of din/en.
REQ-033 Reset mid-sequence SHALL discard partial matches; after release, a full pattern after a fresh cfg_load is required before any match.

Structure
REQ-034 State encoding (IDLE/RUN) and the minimum-length constant (2) SHALL live in the shared fsm package.
REQ-035 The saturating counter SHALL be a sub-module sat_counter (parameter W; inputs clk, rst, clr, inc; output q).
REQ-036 Target size 120-400 lines RTL; no latches; next-state logic with default assignments.

Verification
REQ-037 Overlap: load pattern 5'b11011, len 5, overlap=1, Mealy; stream 1,1,0,1,1,0,1,1 -> match on bits 4 and 7 (0-based), match_cnt=2.
REQ-038 Non-overlap: same stream, overlap=0 -> match only on bit 4, match_cnt=1.
REQ-039 Moore: pattern 3'b101, len 3, overlap=1; stream 1,0,1,0,1 -> match one cycle after bits 2 and 4, never same-cycle.
REQ-040 en gaps: pattern 11011 with en=0 cycles inserted between every bit -> same detections as REQ-037; no match in en=0 cycles.
REQ-041 Config errors: cfg_len=0, then cfg_len=MAX_LEN+1 -> cfg_err=1, match stays 0; then valid load -> cfg_err=0, RUN.
REQ-042 Reset/saturation: rst low after 4 bits of 11011 -> all outputs 0, no match on next bit; with CNT_W=2, 5 overlap hits -> match_cnt=3.
